seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Upstream driver for the hex-to-seven-segment decoder on a multiplexed multi-digit display. It accepts a packed multi-digit hex value through a valid/ready load port and buffers it so a frame is never torn. It time-multiplexes the digits at a programmable refresh rate, presenting one 4-bit nibble per scan slot to the decoder together with a one-hot digit enable.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8)
TICK_DIV, 1000, clock cycles each digit stays selected (>=2)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  scan enable; low = display dark, scan frozen
value_in  input  4*NUM_DIGITS  packed hex value; digit 0 = value_in[3:0] (rightmost)
load_valid  input  1  request to load value_in
load_ready  output  1  block can accept a load this cycle
digit_hex  output  4  nibble of the currently selected digit; drives the decoder inHex
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable
digit_blank  output  1  current digit is to be shown dark
frame_start  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- State:
  - prescaler cnt, range 0..TICK_DIV-1
  - digit index idx, range 0..NUM_DIGITS-1
  - display register disp
  - pending register pend
  - pending flag pflag
- Reset (sync, priority over everything):
  - cnt=0, idx=0, disp=0, pend=0, pflag=0, frame_start=0.
  - Resulting outputs: digit_sel=1 (bit 0), digit_hex=0, digit_blank=0, load_ready=1.
  - Reset mid-scan or mid-pending discards the pending value.
- Load handshake:
  - load_ready = ~pflag (combinational).
  - Transfer occurs when load_valid && load_ready: pend<=value_in, pflag<=1.
  - load_valid while load_ready=0 is ignored. There is no queuing; the upstream must hold or retry.
- Scan, when enable=1:
  - tick = (cnt==TICK_DIV-1).
  - cnt increments each cycle and wraps to 0 on tick.
  - On tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Frame boundary = tick && idx==NUM_DIGITS-1. At the boundary:
  - If pflag=1: disp<=pend and pflag<=0. The new value is first visible on digit 0 of the next frame.
  - frame_start is registered and is 1 in the cycle after the boundary edge, i.e. the first cycle with idx=0.
- Boundary and load in the same cycle: load_ready is still 0 that cycle, so the load is ignored. load_ready returns to 1 on the next cycle.
- enable=0:
  - cnt and idx hold; digit_sel=0; digit_blank=1; frame_start=0.
  - If pflag=1, commit disp<=pend and pflag<=0 on the next edge (no frame in progress).
  - When enable rises again, scanning resumes from the held cnt/idx.
- Outputs (combinational from registers, zero latency from idx):
  - digit_hex = disp[4*idx +: 4].
  - digit_sel = enable && !digit_blank ? (1<<idx) : 0.
- Width rules: idx width = clog2(NUM_DIGITS) and cnt width = clog2(TICK_DIV), with no overflow beyond the wrap points.

Optional Feature:
- Macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
- Defined:
  - digit_blank=1 for every digit above the most significant nonzero nibble of disp.
  - Digit 0 is never blanked, so disp=0 shows a single "0".
  - A blanked digit's digit_sel bit is 0; digit_hex is still driven.
- Undefined: digit_blank = ~enable only, and all digits are always shown.

Test Plan:
Bench parameters: NUM_DIGITS=4, TICK_DIV=4.
1. Reset held 2 cycles then released -> digit_sel=4'b0001, digit_hex=0, load_ready=1, frame_start=0; idx advances every 4 cycles in order 0,1,2,3,0; frame_start pulses once per 16 cycles.
2. Load 16'h1234 one cycle after reset -> load_ready=0 until the boundary at cycle 15; the next frame shows digit_hex 4,3,2,1 on digit_sel 0001,0010,0100,1000, each held 4 cycles; load_ready=1 from then on.
3. Load 16'hABCD, then assert 16'h5678 two cycles later before the boundary -> second load ignored (load_ready=0); the following frame shows D,C,B,A; 5678 never appears.
4. enable=0 at idx=2 with a pending 16'h00FF -> digit_sel=0 and digit_blank=1 next cycle; disp=00FF committed next edge; after re-enable, scanning resumes at idx=2 with the remaining cnt.
5. Reset asserted at idx=2 with pflag=1 -> next cycle idx=0, disp=0, load_ready=1; the pending value is never displayed.
6. SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN defined:
   - Load 16'h0050 -> digits 3 and 2 blank (sel bit 0); digit 1 shows 5; digit 0 shows 0.
   - Load 16'h0000 -> only digit 0 selected.
   - Undefined build: all four digits are selected.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Multiplexed multi-digit display scanner: buffered valid/ready load, programmable refresh.
// Optional leading-zero blanking when SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN is defined.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              digit_hex,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pflag_q, pflag_d;
  logic                    fs_q, fs_d;

  logic tick, boundary, accept, commit;
  logic [NUM_DIGITS-1:0] sel_onehot;

  always_comb begin
    tick     = enable && (cnt_q == LAST_CNT);
    boundary = tick && (idx_q == LAST_IDX);
    accept   = load_valid && !pflag_q;
    // With the scan frozen there is no frame to tear, so commit immediately.
    commit   = pflag_q && (boundary || !enable);

    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    fs_d    = boundary;

    if (enable) begin
      if (tick) begin
        cnt_d = '0;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (commit) begin
      disp_d  = pend_q;
      pflag_d = 1'b0;
    end
    if (accept) begin
      pend_d  = value_in;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    digit_hex  = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_hex     = disp_q[4*i +: 4];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_idx;

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 is always lit.
  always_comb begin
    msd_idx = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
    end
  end

  assign digit_blank = !enable || (idx_q > msd_idx);
`else
  assign digit_blank = !enable;
`endif

  assign digit_sel   = (enable && !digit_blank) ? sel_onehot : '0;
  assign load_ready  = !pflag_q;
  assign frame_start = fs_q && enable;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized and directed bench for seven_segment_scanner (NUM_DIGITS=4, TICK_DIV=4),
// checked against a scan-position reference model.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] value_in = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  digit_hex;
  logic [3:0]  digit_sel;
  logic        digit_blank;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  seven_segment_scanner #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .value_in    (value_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digit_hex   (digit_hex),
    .digit_sel   (digit_sel),
    .digit_blank (digit_blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: pos counts enabled cycles within a 16-cycle frame.
  int          pos = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pflag = 0;
  bit          m_fs = 0;

  function automatic int m_idx();
    return (pos / 4) % 4;
  endfunction

  function automatic bit m_blank();
    int msd;
    if (!enable) return 1'b1;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 1; i < 4; i++)
      if (((m_disp >> (4 * i)) & 16'hF) != 0) msd = i;
    return m_idx() > msd;
`else
    msd = 0;
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_sel();
    return m_blank() ? 4'b0000 : 4'(1 << m_idx());
  endfunction

  function automatic logic [3:0] m_hex();
    return 4'((m_disp >> (4 * m_idx())) & 16'hF);
  endfunction

  function automatic bit m_ready();
    return !m_pflag;
  endfunction

  function automatic bit m_fso();
    return m_fs && enable;
  endfunction

  task automatic step();
    bit bnd, acc, cm;
    @(posedge clk);
    if (reset) begin
      pos = 0; m_disp = '0; m_pend = '0; m_pflag = 0; m_fs = 0;
    end else begin
      bnd = enable && (pos == 15);
      acc = load_valid && !m_pflag;
      cm  = m_pflag && (bnd || !enable);
      m_fs = bnd;
      if (cm) begin m_disp = m_pend; m_pflag = 0; end
      if (acc) begin m_pend = value_in; m_pflag = 1; end
      if (enable) pos = (pos + 1) % 16;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses = 0;
    reset = 1; enable = 1; load_valid = 0; value_in = '0;
    step(); step();
    reset = 0;
    #1;
    n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL reset_sel: got %b expected %b", digit_sel, 4'b0001); end
    n_cmp++; if (digit_hex !== 4'h0) begin n_err++; $display("FAIL reset_hex: got %h expected %h", digit_hex, 4'h0); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    for (int c = 0; c < 33; c++) begin
      if (c != 0) #1;
      n_cmp++; if (digit_sel !== m_sel()) begin n_err++; $display("FAIL scan_sel c=%0d: got %b expected %b", c, digit_sel, m_sel()); end
      n_cmp++; if (frame_start !== m_fso()) begin n_err++; $display("FAIL scan_fs c=%0d: got %b expected %b", c, frame_start, m_fso()); end
      if (frame_start === 1'b1) pulses++;
      step();
    end
    n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL fs_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_load();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 40; c++) begin
      load_valid = (c == 0); value_in = 16'h1234;
      #1;
      n_cmp++; if (load_ready !== m_ready()) begin n_err++; $display("FAIL load_ready c=%0d: got %b expected %b", c, load_ready, m_ready()); end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL load_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      n_cmp++; if (digit_sel !== m_sel()) begin n_err++; $display("FAIL load_sel c=%0d: got %b expected %b", c, digit_sel, m_sel()); end
      step();
    end
    load_valid = 0;
  endtask

  task automatic test_ignored_load();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 40; c++) begin
      load_valid = (c == 0) || (c == 2);
      value_in = (c == 0) ? 16'hABCD : 16'h5678;
      #1;
      n_cmp++; if (load_ready !== m_ready()) begin n_err++; $display("FAIL ign_ready c=%0d: got %b expected %b", c, load_ready, m_ready()); end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL ign_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      step();
    end
    load_valid = 0;
  endtask

  task automatic test_disable();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 25; c++) begin
      load_valid = (c == 0); value_in = 16'h00FF;
      enable = !(c >= 9 && c < 13);
      #1;
      n_cmp++; if (digit_sel !== m_sel()) begin n_err++; $display("FAIL dis_sel c=%0d: got %b expected %b", c, digit_sel, m_sel()); end
      n_cmp++; if (digit_blank !== m_blank()) begin n_err++; $display("FAIL dis_blank c=%0d: got %b expected %b", c, digit_blank, m_blank()); end
      n_cmp++; if (frame_start !== m_fso()) begin n_err++; $display("FAIL dis_fs c=%0d: got %b expected %b", c, frame_start, m_fso()); end
      n_cmp++; if (load_ready !== m_ready()) begin n_err++; $display("FAIL dis_ready c=%0d: got %b expected %b", c, load_ready, m_ready()); end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL dis_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      step();
    end
    load_valid = 0; enable = 1;
  endtask

  task automatic test_reset_mid();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 30; c++) begin
      load_valid = (c == 0); value_in = 16'h9ABC;
      reset = (c == 9);
      #1;
      if (c == 10) begin
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL rmid_sel: got %b expected 0001", digit_sel); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b expected 1", load_ready); end
      end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL rmid_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      step();
    end
    load_valid = 0; reset = 0;
  endtask

  task automatic test_blank();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 64; c++) begin
      load_valid = (c == 0) || (c == 32);
      value_in = (c == 0) ? 16'h0050 : 16'h0000;
      #1;
      n_cmp++; if (digit_sel !== m_sel()) begin n_err++; $display("FAIL blank_sel c=%0d: got %b expected %b", c, digit_sel, m_sel()); end
      n_cmp++; if (digit_blank !== m_blank()) begin n_err++; $display("FAIL blank_blank c=%0d: got %b expected %b", c, digit_blank, m_blank()); end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL blank_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      step();
    end
    load_valid = 0;
  endtask

  task automatic test_random();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 1500; c++) begin
      reset      = ($urandom_range(199) == 0);
      enable     = ($urandom_range(7) != 0);
      load_valid = ($urandom_range(3) == 0);
      value_in   = 16'($urandom);
      #1;
      n_cmp++; if (digit_sel !== m_sel()) begin n_err++; $display("FAIL rnd_sel c=%0d: got %b expected %b", c, digit_sel, m_sel()); end
      n_cmp++; if (digit_blank !== m_blank()) begin n_err++; $display("FAIL rnd_blank c=%0d: got %b expected %b", c, digit_blank, m_blank()); end
      n_cmp++; if (digit_hex !== m_hex()) begin n_err++; $display("FAIL rnd_hex c=%0d: got %h expected %h", c, digit_hex, m_hex()); end
      n_cmp++; if (load_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, load_ready, m_ready()); end
      n_cmp++; if (frame_start !== m_fso()) begin n_err++; $display("FAIL rnd_fs c=%0d: got %b expected %b", c, frame_start, m_fso()); end
      step();
    end
    reset = 0; enable = 1; load_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_ignored_load();
    test_disable();
    test_reset_mid();
    test_blank();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
